frog_sprite_render: RTL and testbench

Pixel stage directly downstream of the 640x480 timing generator for SuperFrog. Consumes the generator's screen position, sync and data-enable signals, tracks the frog's grid position from four direction buttons, and outputs 4-bit-per-channel VGA colour. Syncs are delay-matched to the colour pipeline. Position changes only at the start of vertical blanking, so a frame never tears.

---
 rtl/frog_sprite_render.sv | 245 ++++++++++++++++++++++++
 tb/tb_frog_sprite_render.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_sprite_render.sv
// frog_sprite_render
//   Pixel stage that sits directly behind a 640x480 timing generator. It
//   draws a single square "frog" sprite over a flat background. The frog
//   hops one grid step per frame tick in response to the four direction
//   buttons. Position changes only at the start of vertical blanking, so a
//   visible frame never tears. Colour and syncs leave two cycles after
//   sx/sy/de/sync arrive, and they stay mutually aligned.
//
// Ports
//   clk_pix, rst_pix_n        pixel clock; synchronous active-low reset
//   sx, sy                    screen position from the timing generator
//   de, hsync, vsync          data enable and negative-polarity syncs
//   btn_up/down/left/right    button levels, already synchronised to clk_pix
//   vga_r, vga_g, vga_b       4-bit colour, black outside the active area
//   vga_hs, vga_vs, vga_de    syncs and enable delayed to match the colour
//   frog_x, frog_y            current top-left corner of the frog
//   hop_busy                  high while the hop animation/cooldown runs
module frog_sprite_render #(
    parameter int          SPRITE_SIZE = 32,
    parameter int          STEP        = 32,
    parameter int          HOP_FRAMES  = 8,
    parameter int          X_INIT      = 304,
    parameter int          Y_INIT      = 448,
    parameter logic [11:0] BG_COLOR    = 12'h262,
    parameter logic [11:0] FROG_COLOR  = 12'h0F0,
    parameter logic [11:0] HOP_COLOR   = 12'hFF0
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       hop_busy
);

    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] SIZE_W   = 11'(SPRITE_SIZE);
    localparam logic [10:0] X_MAX    = 11'(640 - SPRITE_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(480 - SPRITE_SIZE);
    localparam logic [9:0]  X_INIT_W = 10'(X_INIT);
    localparam logic [9:0]  Y_INIT_W = 10'(Y_INIT);
    localparam logic [7:0]  HOP_LOAD = 8'(HOP_FRAMES - 1);

    typedef enum logic {IDLE, HOP} state_t;

    // ------------------------------------------------------------------
    // Frame tick: first pixel of the first blanking line.
    // ------------------------------------------------------------------
    logic tick;
    assign tick = (sx == 10'd0) && (sy == 10'd480);

    // ------------------------------------------------------------------
    // Button capture. Bit order is {up, down, left, right}.
    // The edge detector is disarmed for the first cycle after reset. This
    // keeps a button held through reset from looking like a fresh press.
    // ------------------------------------------------------------------
    logic [3:0] btn_now;
    logic [3:0] btn_q;
    logic [3:0] req;
    logic       armed;
    logic [3:0] rise;

    assign btn_now = {btn_up, btn_down, btn_left, btn_right};
    assign rise    = btn_now & ~btn_q & {4{armed}};

    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            btn_q <= '0;
            req   <= '0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn_now;
            armed <= 1'b1;
            // Requests are evaluated on the tick, so they are dropped after it.
            if (tick) req <= '0;
            else      req <= req | rise;
        end
    end

    // ------------------------------------------------------------------
    // Move selection: only the highest-priority pending request is
    // considered. If it is illegal, no move happens this frame.
    // ------------------------------------------------------------------
    logic [10:0] x_w, y_w;
    logic        move_ok;
    logic [9:0]  move_x, move_y;

    assign x_w = {1'b0, frog_x};
    assign y_w = {1'b0, frog_y};

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        move_ok = 1'b0;
        move_x  = frog_x;
        move_y  = frog_y;
        if (req[3]) begin
            if (y_w >= STEP_W) begin
                move_ok = 1'b1;
                move_y  = 10'(y_w - STEP_W);
            end
        end else if (req[2]) begin
            if (y_w + STEP_W <= Y_MAX) begin
                move_ok = 1'b1;
                move_y  = 10'(y_w + STEP_W);
            end
        end else if (req[1]) begin
            if (x_w >= STEP_W) begin
                move_ok = 1'b1;
                move_x  = 10'(x_w - STEP_W);
            end
        end else if (req[0]) begin
            if (x_w + STEP_W <= X_MAX) begin
                move_ok = 1'b1;
                move_x  = 10'(x_w + STEP_W);
            end
        end
    end

    // ------------------------------------------------------------------
    // Hop FSM: IDLE accepts a move on a tick. HOP counts ticks down and
    // ignores requests.
    // ------------------------------------------------------------------
    state_t     state, state_next;
    logic [7:0] hop_cnt, hop_cnt_next;
    logic [9:0] frog_x_next, frog_y_next;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state   <= IDLE;
            hop_cnt <= '0;
            frog_x  <= X_INIT_W;
            frog_y  <= Y_INIT_W;
        end else begin
            state   <= state_next;
            hop_cnt <= hop_cnt_next;
            frog_x  <= frog_x_next;
            frog_y  <= frog_y_next;
        end
    end

    always_comb begin
        state_next   = state;
        hop_cnt_next = hop_cnt;
        frog_x_next  = frog_x;
        frog_y_next  = frog_y;
        case (state)
            IDLE: begin
                if (tick && move_ok) begin
                    frog_x_next  = move_x;
                    frog_y_next  = move_y;
                    hop_cnt_next = HOP_LOAD;
                    state_next   = HOP;
                end
            end
            HOP: begin
                // Leaving HOP consumes this tick, so no move happens on it.
                if (tick) begin
                    if (hop_cnt == 8'd0) state_next   = IDLE;
                    else                 hop_cnt_next = hop_cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hop_busy = (state == HOP);

    // ------------------------------------------------------------------
    // Stage 1: hit test against the current frog position, plus the
    // delayed timing signals.
    // ------------------------------------------------------------------
    logic [10:0] sx_w, sy_w;
    logic        hit;
    logic        hit_q, hop_q, de_q, hs_q, vs_q;

    assign sx_w = {1'b0, sx};
    assign sy_w = {1'b0, sy};
    assign hit  = (sx_w >= x_w) && (sx_w < x_w + SIZE_W) &&
                  (sy_w >= y_w) && (sy_w < y_w + SIZE_W);

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            hit_q <= 1'b0;
            hop_q <= 1'b0;
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            hit_q <= hit;
            hop_q <= hop_busy;
            de_q  <= de;
            hs_q  <= hsync;
            vs_q  <= vsync;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select and output registers.
    // ------------------------------------------------------------------
    logic [11:0] pix;

    always_comb begin
        pix = 12'h000;
        if (de_q) begin
            if (hit_q) pix = hop_q ? HOP_COLOR : FROG_COLOR;
            else       pix = BG_COLOR;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_de <= 1'b0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            vga_r  <= pix[11:8];
            vga_g  <= pix[7:4];
            vga_b  <= pix[3:0];
            vga_de <= de_q;
            vga_hs <= hs_q;
            vga_vs <= vs_q;
        end
    end

endmodule

// File: tb/tb_frog_sprite_render.sv
// tb_frog_sprite_render
//   Directed bench for frog_sprite_render. Inputs change on the falling
//   edge and outputs are sampled on the falling edge. The design runs on
//   the rising edge, so a value driven at falling edge k shows on the
//   outputs at falling edge k+2.
module tb_frog_sprite_render;

    logic       clk_pix = 1'b0;
    logic       rst_pix_n;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de;
    logic [9:0] frog_x, frog_y;
    logic       hop_busy;

    int total = 0;
    int bad   = 0;

    frog_sprite_render dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .sx        (sx),
        .sy        (sy),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .vga_de    (vga_de),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .hop_busy  (hop_busy)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic park();
        sx = 10'd100; sy = 10'd100; de = 1'b1; hsync = 1'b1; vsync = 1'b1;
    endtask

    // One tick is seen by exactly one rising edge. On return the frog
    // registers already hold their post-tick values.
    task automatic do_tick();
        @(negedge clk_pix);
        sx = 10'd0; sy = 10'd480; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        @(negedge clk_pix);
        park();
    endtask

    // Button mask order is {up, down, left, right}.
    task automatic press(input logic [3:0] m);
        @(negedge clk_pix);
        {btn_up, btn_down, btn_left, btn_right} = m;
        @(negedge clk_pix);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        @(negedge clk_pix);
    endtask

    task automatic check_pos(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic busy);
        check({name, " x"},    {6'd0, frog_x}, {6'd0, x});
        check({name, " y"},    {6'd0, frog_y}, {6'd0, y});
        check({name, " busy"}, {15'd0, hop_busy}, {15'd0, busy});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] d1, d2, nv;
        logic [9:0] lines [9];
        lines = '{10'd0, 10'd1, 10'd479, 10'd480, 10'd489,
                  10'd490, 10'd491, 10'd492, 10'd524};

        // Frog sits at (304,448)..(335,479) for the vector table.
        vecs[0] = '{10'd310, 10'd450, 1'b1, 1'b1, 1'b1, 12'h0F0};
        vecs[1] = '{10'd0,   10'd450, 1'b1, 1'b1, 1'b1, 12'h262};
        vecs[2] = '{10'd700, 10'd450, 1'b0, 1'b0, 1'b1, 12'h000};
        vecs[3] = '{10'd303, 10'd450, 1'b1, 1'b1, 1'b1, 12'h262};
        vecs[4] = '{10'd304, 10'd448, 1'b1, 1'b1, 1'b1, 12'h0F0};
        vecs[5] = '{10'd335, 10'd479, 1'b1, 1'b1, 1'b1, 12'h0F0};
        vecs[6] = '{10'd336, 10'd479, 1'b1, 1'b1, 1'b1, 12'h262};
        vecs[7] = '{10'd320, 10'd447, 1'b1, 1'b1, 1'b1, 12'h262};
        vecs[8] = '{10'd320, 10'd490, 1'b0, 1'b1, 1'b0, 12'h000};

        // ---- Reset: the inputs try to disturb the outputs, but reset must win.
        rst_pix_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        sx = 10'd310; sy = 10'd450; de = 1'b1; hsync = 1'b0; vsync = 1'b0;
        repeat (4) @(negedge clk_pix);
        check("rst rgb", {4'd0, vga_r, vga_g, vga_b}, 16'h0000);
        check("rst vga_de", {15'd0, vga_de}, 16'd0);
        check("rst vga_hs", {15'd0, vga_hs}, 16'd1);
        check("rst vga_vs", {15'd0, vga_vs}, 16'd1);
        check_pos("rst", 10'd304, 10'd448, 1'b0);
        rst_pix_n = 1'b1;
        park();

        // ---- Table: colour/latency with the frog idle at its reset spot.
        for (int i = 0; i < NVEC + 2; i++) begin
            @(negedge clk_pix);
            if (i >= 2) begin
                check($sformatf("vec%0d rgb", i - 2), {4'd0, vga_r, vga_g, vga_b},
                      {4'd0, vecs[i-2].rgb});
                check($sformatf("vec%0d de/hs/vs", i - 2), {13'd0, vga_de, vga_hs, vga_vs},
                      {13'd0, vecs[i-2].de, vecs[i-2].hs, vecs[i-2].vs});
            end
            if (i < NVEC) begin
                sx = vecs[i].sx; sy = vecs[i].sy; de = vecs[i].de;
                hsync = vecs[i].hs; vsync = vecs[i].vs;
            end else begin
                park();
            end
        end

        // ---- At the bottom edge, down is illegal. Left is lower priority and not tried.
        press(4'b0110);
        do_tick();
        check_pos("down clamp", 10'd304, 10'd448, 1'b0);

        // ---- Single up move, then the hop colour, then the cooldown.
        press(4'b1000);
        do_tick();
        check_pos("up move", 10'd304, 10'd416, 1'b1);
        @(negedge clk_pix);
        sx = 10'd310; sy = 10'd420; de = 1'b1;
        @(negedge clk_pix);
        park();
        @(negedge clk_pix);
        check("hop colour", {4'd0, vga_r, vga_g, vga_b}, 16'h0FF0);
        press(4'b0010);
        for (int k = 1; k <= 7; k++) begin
            do_tick();
            check($sformatf("cooldown tick%0d busy", k), {15'd0, hop_busy}, 16'd1);
        end
        do_tick();
        check_pos("hop end", 10'd304, 10'd416, 1'b0);
        do_tick();
        check_pos("hop press dropped", 10'd304, 10'd416, 1'b0);

        // ---- Down and right in the same frame: only down applies.
        press(4'b0101);
        do_tick();
        check_pos("down over right", 10'd304, 10'd448, 1'b1);
        repeat (8) do_tick();
        check("down cooldown end", {15'd0, hop_busy}, 16'd0);

        // ---- Walk left until less than one step remains, then clamp.
        repeat (9) begin
            press(4'b0010);
            do_tick();
            repeat (8) do_tick();
        end
        check_pos("walk left", 10'd16, 10'd448, 1'b0);
        press(4'b0010);
        do_tick();
        check_pos("left clamp", 10'd16, 10'd448, 1'b0);
        do_tick();
        check_pos("left clamp after", 10'd16, 10'd448, 1'b0);

        // ---- Reset on a tick cycle during HOP, with up held through reset.
        press(4'b1000);
        do_tick();
        check_pos("pre-reset move", 10'd16, 10'd416, 1'b1);
        do_tick();
        @(negedge clk_pix);
        rst_pix_n = 1'b0;
        btn_up = 1'b1;
        sx = 10'd0; sy = 10'd480; de = 1'b0;
        @(negedge clk_pix);
        check_pos("reset mid-hop", 10'd304, 10'd448, 1'b0);
        rst_pix_n = 1'b1;
        park();
        repeat (3) @(negedge clk_pix);
        do_tick();
        check_pos("held through reset", 10'd304, 10'd448, 1'b0);
        btn_up = 1'b0;
        press(4'b1000);
        do_tick();
        check_pos("press after reset", 10'd304, 10'd416, 1'b1);

        // ---- Sync alignment across representative lines of a frame.
        park();
        repeat (2) @(negedge clk_pix);
        d1 = 3'b111;
        d2 = 3'b111;
        foreach (lines[l]) begin
            for (int x = 0; x < 800; x++) begin
                @(negedge clk_pix);
                check($sformatf("sync y%0d x%0d", lines[l], x),
                      {13'd0, vga_hs, vga_vs, vga_de}, {13'd0, d2});
                nv[2] = !(x >= 656 && x < 752);
                nv[1] = !(lines[l] >= 10'd490 && lines[l] < 10'd492);
                nv[0] = (x < 640) && (lines[l] < 10'd480);
                d2 = d1;
                d1 = nv;
                sx = 10'(x); sy = lines[l];
                hsync = nv[2]; vsync = nv[1]; de = nv[0];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
